// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the MIPS front-end fetch sequencer.
// Sequencer state encoding, PC/immediate widths and the branch target helper.
package mips_ctrl_pkg;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned IMM_W = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DSLOT = 2'd2
  } state_e;

  // pc + 4 + (sext(imm) << 2), carry out of bit 31 dropped
  function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0]  pc,
                                                    input logic [IMM_W-1:0] imm);
    logic [PC_W-1:0] off;
    off = {{(PC_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    return pc + PC_W'(4) + off;
  endfunction

endpackage

// File: rtl/tracker_fifo.sv
// In-order tracker of in-flight fetch PCs; entry 0 is always the oldest.
// Synchronous clear may retain the oldest clr_keep entries (delay-slot survivor).
module tracker_fifo #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  input  logic             clr,
  input  logic [CNT_W-1:0] clr_keep,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_pop;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    mem_d   = mem_q;
    cnt_pop = cnt_q;
    if (pop && (cnt_q != '0)) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      cnt_pop = cnt_q - 1'b1;
    end
    cnt_d = cnt_pop;
    // push lands after the pop shift, so same-cycle push/pop keeps order
    if (push && (32'(cnt_pop) < DEPTH)) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == cnt_pop) begin
          mem_d[i] = push_data;
        end
      end
      cnt_d = cnt_pop + 1'b1;
    end
    if (clr && (cnt_d > clr_keep)) begin
      cnt_d = clr_keep;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign head_data = mem_q[0];
  assign count     = cnt_q;

endmodule

// File: rtl/branch_redirect_sequencer.sv
// Fetch PC sequencer with in-flight limit, branch resolution and flush/redirect.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the delay-slot instruction alive.
module branch_redirect_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned     DEPTH    = 3,
  parameter logic [31:0]     RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fetch_req,
  input  logic        fetch_ack,
  output logic [31:0] fetch_pc,
  input  logic        exec_valid,
  input  logic        exec_branch,
  input  logic        exec_zero,
  input  logic [15:0] exec_imm,
  output logic        flush,
  output logic [3:0]  inflight,
  output logic        protocol_err
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] head_pc;
  logic [PC_W-1:0] target;
  logic [3:0]      cnt;
  logic            push, pop, taken;
  logic            clr;
  logic [3:0]      clr_keep;
  logic            perr_q;
`ifdef BRANCH_DELAY_SLOT_EN
  logic [PC_W-1:0] target_q, target_d;
`endif

  tracker_fifo #(
    .DEPTH (DEPTH),
    .W     (PC_W),
    .CNT_W (4)
  ) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (pc_q),
    .pop       (pop),
    .clr       (clr),
    .clr_keep  (clr_keep),
    .head_data (head_pc),
    .count     (cnt)
  );

  always_comb begin
    fetch_req = (state_q == ST_RUN) && (32'(cnt) < DEPTH);
`ifdef BRANCH_DELAY_SLOT_EN
    fetch_req = fetch_req || (state_q == ST_DSLOT);
`endif
    push   = fetch_req && fetch_ack;
    pop    = exec_valid && (state_q == ST_RUN) && (cnt != '0);
    taken  = pop && exec_branch && exec_zero;
    target = branch_target(head_pc, exec_imm);
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    clr      = 1'b0;
    clr_keep = '0;
`ifdef BRANCH_DELAY_SLOT_EN
    target_d = target_q;
`endif
    if (push) begin
      pc_d = pc_q + PC_W'(4);
    end
    case (state_q)
      ST_RUN: begin
        if (taken) begin
          clr = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
          // survivor is whatever sits behind the branch, including a same-cycle push
          if ((cnt > 4'd1) || push) begin
            clr_keep = 4'd1;
            state_d  = ST_FLUSH;
            pc_d     = target;
          end else begin
            state_d  = ST_DSLOT;
            target_d = target;
            pc_d     = head_pc + PC_W'(4);
          end
`else
          state_d = ST_FLUSH;
          pc_d    = target;
`endif
        end
      end
      ST_FLUSH: state_d = ST_RUN;
`ifdef BRANCH_DELAY_SLOT_EN
      ST_DSLOT: begin
        if (push) begin
          state_d = ST_FLUSH;
          pc_d    = target_q;
        end
      end
`endif
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (exec_valid && (state_q != ST_FLUSH) && (cnt == '0)) begin
        perr_q <= 1'b1;
      end
    end
  end

`ifdef BRANCH_DELAY_SLOT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
    end else begin
      target_q <= target_d;
    end
  end
`endif

  assign fetch_pc     = pc_q;
  assign flush        = (state_q == ST_FLUSH);
  assign inflight     = cnt;
  assign protocol_err = perr_q;

endmodule
